// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory stage.
// Lane width and lane count are fixed here; vec_t is the packed 16 x 8-bit vector.
package vmem_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned LANES = 16;
  localparam int unsigned LW    = $clog2(LANES);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  typedef logic [N-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;

endpackage

// File: rtl/vmem_lane_seq.sv
// Lane counter and lane address generator for the vector memory stage.
// The address is base + lane and deliberately wraps modulo 2^AW.
module vmem_lane_seq import vmem_pkg::*; #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [AW-1:0] base_i,
  output logic [LW-1:0] lane_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [LW-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (clr_i) begin
      lane_d = '0;
    end else if (adv_i) begin
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign lane_o = lane_q;
  assign addr_o = base_i + AW'(lane_q);
  assign last_o = (lane_q == LW'(LANES - 1));

endmodule

// File: rtl/vector_mem_stage.sv
// Vector memory stage: serialises a 16-lane load/store onto a byte-wide memory port.
// Optional per-lane masking is enabled with `define VMEM_LANE_MASK_EN.
module vector_mem_stage import vmem_pkg::*; #(
  parameter int unsigned AW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [AW-1:0]           Addr,
  input  logic [LANES-1:0][N-1:0] WD,
  input  logic [LANES-1:0][N-1:0] ALUOut,
  input  logic [3:0]              WA3,
  input  logic                    RegWrite,
  input  logic                    MemtoReg,
`ifdef VMEM_LANE_MASK_EN
  input  logic [LANES-1:0]        LaneMask,
`endif
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic [N-1:0]            mem_rdata,
  input  logic                    mem_ack,
  output logic [LANES-1:0][N-1:0] RD,
  output logic [LANES-1:0][N-1:0] ALUOutQ,
  output logic [3:0]              WA3Q,
  output logic                    RegWriteQ,
  output logic                    MemtoRegQ,
  output logic                    stall,
  output logic                    cargar
);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  vec_t          wd_q, wd_d;
  vec_t          rd_q, rd_d;
  vec_t          alu_q, alu_d;
  logic [3:0]    wa3_q, wa3_d;
  logic          regwrite_q, regwrite_d;
  logic          memtoreg_q, memtoreg_d;
  logic          store_q, store_d;

  logic          seq_clr, seq_adv, last_lane, lane_en, is_mem;
  logic [LW-1:0] lane;

`ifdef VMEM_LANE_MASK_EN
  logic [LANES-1:0] mask_q, mask_d;
  assign lane_en = mask_q[lane];
`else
  assign lane_en = 1'b1;
`endif

  assign is_mem = MemRead | MemWrite;

  vmem_lane_seq #(
    .AW(AW)
  ) u_lane_seq (
    .clk   (clk),
    .reset (reset),
    .clr_i (seq_clr),
    .adv_i (seq_adv),
    .base_i(base_q),
    .lane_o(lane),
    .addr_o(mem_addr),
    .last_o(last_lane)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    wa3_d      = wa3_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    store_d    = store_q;
`ifdef VMEM_LANE_MASK_EN
    mask_d     = mask_q;
`endif
    seq_clr    = 1'b0;
    seq_adv    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          alu_d      = ALUOut;
          wa3_d      = WA3;
          regwrite_d = RegWrite;
          memtoreg_d = MemtoReg;
          if (is_mem) begin
            base_d  = Addr;
            wd_d    = WD;
            store_d = MemWrite;
`ifdef VMEM_LANE_MASK_EN
            mask_d  = LaneMask;
`endif
            seq_clr = 1'b1;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        // Masked-off lanes retire in one cycle without waiting for an ack.
        if (mem_ack || !lane_en) begin
          seq_adv = 1'b1;
          if (!store_q) begin
            rd_d[lane] = lane_en ? mem_rdata : '0;
          end
          if (last_lane) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      wa3_q      <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      store_q    <= 1'b0;
`ifdef VMEM_LANE_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      wa3_q      <= wa3_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      store_q    <= store_d;
`ifdef VMEM_LANE_MASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

  // stall and cargar also respond combinationally to a start seen in IDLE.
  always_comb begin
    mem_req   = (state_q == StAccess) && lane_en;
    mem_we    = mem_req && store_q;
    mem_wdata = wd_q[lane];
    stall     = (state_q == StAccess) || ((state_q == StIdle) && start && is_mem);
    cargar    = (state_q == StDone) || ((state_q == StIdle) && start && !is_mem);
  end

  assign RD        = rd_q;
  assign ALUOutQ   = alu_q;
  assign WA3Q      = wa3_q;
  assign RegWriteQ = regwrite_q;
  assign MemtoRegQ = memtoreg_q;

endmodule

// File: tb/tb_vector_mem_stage.sv
// Randomised self-checking bench for vector_mem_stage against a lane-level reference model.
// Define VMEM_LANE_MASK_EN to also exercise lane masking.
module tb_vector_mem_stage;

  localparam int L = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                start, MemRead, MemWrite;
  logic [15:0]         Addr;
  logic [L-1:0][7:0]   WD, ALUOut, RD, ALUOutQ;
  logic [3:0]          WA3, WA3Q;
  logic                RegWrite, MemtoReg, RegWriteQ, MemtoRegQ;
  logic                mem_req, mem_we, mem_ack;
  logic [15:0]         mem_addr;
  logic [7:0]          mem_wdata, mem_rdata;
  logic                stall, cargar;
  logic [L-1:0]        LaneMask;

  vector_mem_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WD       (WD),
    .ALUOut   (ALUOut),
    .WA3      (WA3),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
`ifdef VMEM_LANE_MASK_EN
    .LaneMask (LaneMask),
`endif
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .RD       (RD),
    .ALUOutQ  (ALUOutQ),
    .WA3Q     (WA3Q),
    .RegWriteQ(RegWriteQ),
    .MemtoRegQ(MemtoRegQ),
    .stall    (stall),
    .cargar   (cargar)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]        mem [0:65535];
  logic [L-1:0][7:0] exp_rd, exp_alu;
  logic [3:0]        exp_wa3;
  logic              exp_rw, exp_m2r;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    check_eq({tag, ".rd"}, RD, exp_rd);
    check_eq({tag, ".alu"}, ALUOutQ, exp_alu);
    check_eq({tag, ".wa3"}, {124'd0, WA3Q}, {124'd0, exp_wa3});
    check_eq({tag, ".ctl"}, {126'd0, RegWriteQ, MemtoRegQ}, {126'd0, exp_rw, exp_m2r});
  endtask

  // ack_mode: 0 = ack every cycle, 1 = ack every third cycle, 2 = random.
  // abort_at >= 0 pulls reset once that many lanes have completed.
  task automatic do_op(input string tag, input bit rd_op, input bit wr_op,
                       input logic [15:0] base, input int ack_mode,
                       input logic [L-1:0] mask_in, input bit wd_index, input int abort_at);
    logic [L-1:0][7:0] wd, alu;
    logic [L-1:0]      mask;
    logic [15:0]       q_addr[$];
    logic [7:0]        q_data[$];
    bit                q_we[$];
    bit                is_mem, is_store, done, waiting;
    int                stall_lo, unstable, lat, k;
    logic [15:0]       hold_addr;

    mask = mask_in;
`ifndef VMEM_LANE_MASK_EN
    mask = '1;
`endif
    for (int i = 0; i < L; i++) begin
      wd[i]  = wd_index ? 8'(i) : 8'($urandom);
      alu[i] = 8'($urandom);
    end
    is_mem   = rd_op || wr_op;
    is_store = wr_op;
    done = 1'b0; waiting = 1'b0; stall_lo = 0; unstable = 0; lat = 0;
    hold_addr = '0;

    @(negedge clk);
    start = 1'b1; MemRead = rd_op; MemWrite = wr_op; Addr = base; WD = wd; ALUOut = alu;
    WA3 = 4'($urandom); RegWrite = 1'($urandom); MemtoReg = 1'($urandom); LaneMask = mask;
    #1;
    if (is_mem) begin
      check_eq({tag, ".stall0"}, {127'd0, stall}, 128'd1);
      check_eq({tag, ".cargar0"}, {127'd0, cargar}, 128'd0);
    end else begin
      check_eq({tag, ".cargar0"}, {127'd0, cargar}, 128'd1);
      check_eq({tag, ".noreq"}, {126'd0, mem_req, stall}, 128'd0);
    end
    @(posedge clk);
    exp_alu = alu; exp_wa3 = WA3; exp_rw = RegWrite; exp_m2r = MemtoReg;
    @(negedge clk);
    start = 1'b0; Addr = 16'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);

    if (!is_mem) begin
      #1;
      check_eq({tag, ".cargar1"}, {126'd0, cargar, mem_req}, 128'd0);
      check_q(tag);
      return;
    end

    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (abort_at >= 0 && q_addr.size() == abort_at) begin
        reset = 1'b0;
        #1;
        check_eq({tag, ".rst_out"}, {125'd0, mem_req, stall, cargar}, 128'd0);
        exp_rd = '0; exp_alu = '0; exp_wa3 = '0; exp_rw = 1'b0; exp_m2r = 1'b0;
        check_q({tag, ".rst"});
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          #1;
          check_eq({tag, ".after_rst"}, {125'd0, mem_req, stall, cargar}, 128'd0);
        end
        return;
      end
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (cyc % 3 == 0);
        default: mem_ack = 1'($urandom);
      endcase
      mem_rdata = mem[mem_addr];
      #1;
      if (cargar) begin
        done = 1'b1;
        lat  = cyc;
        check_eq({tag, ".stall_done"}, {127'd0, stall}, 128'd0);
        break;
      end
      if (!stall) stall_lo++;
      if (mem_req) begin
        if (waiting && mem_addr !== hold_addr) unstable++;
        if (mem_ack) begin
          q_addr.push_back(mem_addr);
          q_data.push_back(mem_wdata);
          q_we.push_back(mem_we);
          waiting = 1'b0;
        end else begin
          waiting   = 1'b1;
          hold_addr = mem_addr;
        end
      end
    end
    mem_ack = 1'b0;

    check_eq({tag, ".done"}, {127'd0, done}, 128'd1);
    if (ack_mode == 0) check_eq({tag, ".lat"}, 128'(lat), 128'd17);
    if (ack_mode == 1) check_eq({tag, ".lat"}, 128'(lat), 128'd49);
    check_eq({tag, ".stall_lo"}, 128'(stall_lo), 128'd0);
    check_eq({tag, ".addr_hold"}, 128'(unstable), 128'd0);
    check_eq({tag, ".nreq"}, 128'(q_addr.size()), 128'($countones(mask)));

    k = 0;
    for (int i = 0; i < L; i++) begin
      if (mask[i]) begin
        if (k < q_addr.size()) begin
          check_eq({tag, ".addr"}, {112'd0, q_addr[k]}, {112'd0, 16'(base + 16'(i))});
          check_eq({tag, ".we"}, {127'd0, q_we[k]}, {127'd0, is_store});
          if (is_store) check_eq({tag, ".wdata"}, {120'd0, q_data[k]}, {120'd0, wd[i]});
        end
        k++;
      end
      if (!is_store) exp_rd[i] = mask[i] ? mem[16'(base + 16'(i))] : 8'h00;
    end

    check_q(tag);
    @(negedge clk);
    #1;
    check_eq({tag, ".pulse"}, {126'd0, cargar, stall}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < L; i++) mem[16'h10 + i] = 8'hA0 + 8'(i);
    start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WD = '0; ALUOut = '0;
    WA3 = '0; RegWrite = 1'b0; MemtoReg = 1'b0; LaneMask = '1;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_rd = '0; exp_alu = '0; exp_wa3 = '0; exp_rw = 1'b0; exp_m2r = 1'b0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset.out", {124'd0, mem_req, mem_we, stall, cargar}, 128'd0);
    check_q("reset");
    reset = 1'b1;
    @(negedge clk);

    do_op("load10",   1'b1, 1'b0, 16'h0010, 0, '1, 1'b0, -1);
    do_op("storeWrap", 1'b0, 1'b1, 16'hFFF8, 0, '1, 1'b1, -1);
    do_op("nonmem",   1'b0, 1'b0, 16'h1234, 0, '1, 1'b0, -1);
    do_op("loadWait", 1'b1, 1'b0, 16'h0200, 1, '1, 1'b0, -1);
    do_op("both",     1'b1, 1'b1, 16'h0300, 0, '1, 1'b0, -1);
    do_op("abort",    1'b1, 1'b0, 16'h0400, 0, '1, 1'b0, 7);
    do_op("postRst",  1'b1, 1'b0, 16'h0500, 0, '1, 1'b0, -1);
`ifdef VMEM_LANE_MASK_EN
    do_op("mask00FF", 1'b1, 1'b0, 16'h0010, 0, 16'h00FF, 1'b0, -1);
    do_op("mask0",    1'b1, 1'b0, 16'h0600, 0, 16'h0000, 1'b0, -1);
`endif
    for (int n = 0; n < 16; n++) begin
      do_op("rand", 1'($urandom), 1'($urandom), 16'($urandom), 2, 16'($urandom), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
